change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Money-out counterpart of the vending controller.
- Accepts a change-return request in currency units (multiples of 5) and drives a two-chute coin ejector (5-coin and 10-coin) one coin at a time, with a per-coin ack handshake.
- Tracks coin inventory and rejects requests it cannot satisfy.
- Reports completion, shortage, illegal amounts and ejector faults.

Parameters:
- CNT_W, 6, width of each inventory counter (saturates at 2^CNT_W-1).
- STOCK5_INIT, 8, 5-coin count loaded at reset.
- STOCK10_INIT, 8, 10-coin count loaded at reset.
- ACK_TIMEOUT, 15, max cycles spent in WAIT_ACK before a fault is declared.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  change request present
- req_amount  in  4  requested change value (legal: 0, 5, 10, 15)
- req_ready  out  1  high only in IDLE
- eject5  out  1  one-cycle pulse: drop one 5-coin
- eject10  out  1  one-cycle pulse: drop one 10-coin
- eject_ack  in  1  ejector confirms a coin dropped
- refill_valid  in  1  add coins to inventory (IDLE only)
- refill_sel  in  1  0 = 5-coin, 1 = 10-coin
- refill_cnt  in  CNT_W  coins added
- done  out  1  one-cycle pulse: request fully paid
- short  out  1  one-cycle pulse: inventory insufficient
- bad_amt  out  1  one-cycle pulse: amount not a multiple of 5
- fault  out  1  sticky: ack timeout
- residual  out  4  unpaid value, valid when short pulses
- stock5  out  CNT_W  current 5-coin count
- stock10  out  CNT_W  current 10-coin count

Behaviour:
- Reset: state=IDLE; stock5=STOCK5_INIT; stock10=STOCK10_INIT. All pulse outputs=0, fault=0, residual=0, remaining=0. req_ready=1 from the first post-reset cycle.
- Handshake: request accepted on req_valid && req_ready (cycle T). req_amount is registered into remaining.
- States:
  - IDLE: accepts requests and refills.
  - CHECK: 1 cycle at T+1.
  - EJECT: 1 cycle; exactly one of eject5/eject10 high.
  - WAIT_ACK.
  - FAULT.
- CHECK evaluation:
  - amount not in {0,5,10,15}: bad_amt pulses at T+2, back to IDLE, no ejects.
  - amount 0: done pulses at T+2, no ejects.
  - Feasibility: n10 = min(amt/10, stock10); need5 = (amt - 10*n10)/5. Feasible iff need5 <= stock5.
  - Infeasible: all-or-nothing. short pulses at T+2, residual=amt, back to IDLE, stock unchanged.
  - Feasible: go to EJECT.
- Coin selection in EJECT:
  - eject10 if remaining>=10 and stock10>0; else eject5.
  - First eject pulse occurs at T+2.
- WAIT_ACK:
  - eject_ack is sampled only here; ack during the EJECT cycle is ignored.
  - On ack: decrement the matching stock and subtract 5/10 from remaining.
  - If remaining==0: done pulses the next cycle and state returns to IDLE. Otherwise go to EJECT.
  - Timer clears on entry. When it reaches ACK_TIMEOUT without ack: go to FAULT; fault=1; residual=remaining.
- FAULT: req_ready=0, no ejects, ack ignored. Exits only by reset.
- Refill:
  - Applied in IDLE only; ignored elsewhere.
  - Saturating add (clamps at 2^CNT_W-1).
  - Refill and req_valid in the same IDLE cycle: both taken; CHECK sees the refilled stock.
- Reset mid-dispense: immediate IDLE, inventory reinitialised, remaining discarded.
- Stock never underflows: CHECK guarantees sufficiency.

Optional Feature:
- Macro: PARTIAL_DISPENSE_EN.
- Defined: an infeasible request dispenses the greedy maximum payable (all possible 10s, then 5s). short then pulses the cycle after the last ack, with residual = unpaid value. If nothing is payable, short pulses at T+2.
- Undefined: all-or-nothing behaviour as above.

Decomposition:
- Package change_pkg:
  - state enum (IDLE, CHECK, EJECT, WAIT_ACK, FAULT).
  - Coin value constants COIN5=4'd5, COIN10=4'd10.
  - Legal-amount check function.
- One sub-module, ack_watchdog: loadable down-counter with clear/enable that flags expiry at ACK_TIMEOUT.

Test Plan:
- Reset, then request 15 with stock 8/8 → eject10 at T+2, ack, eject5, ack → done; stock5=7, stock10=7.
- stock10=0, stock5=1, request 10 → short at T+2, residual=10, no eject pulses. With PARTIAL_DISPENSE_EN: one eject5, then short with residual=5.
- Request 7 → bad_amt at T+2, no ejects. Request 0 → done at T+2, no ejects.
- Request 10, withhold ack for 15 cycles → fault=1, residual=10, req_ready=0; later ack and requests ignored; reset clears.
- refill_valid sel=1 cnt=63 with stock10=8 → stock10 saturates at 63. Refill during WAIT_ACK → ignored.
- Assert reset during WAIT_ACK of a 15 request → next cycle IDLE, stock back to 8/8, no done pulse.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types, coin constants and helpers for the change dispenser.
package change_pkg;

    // Dispenser controller states.
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        EJECT,
        WAIT_ACK,
        FAULT
    } state_t;

    // Value of each coin the ejector can drop.
    localparam logic [3:0] COIN5  = 4'd5;
    localparam logic [3:0] COIN10 = 4'd10;

    // Only these amounts can be paid with 5 and 10 coins in a 4-bit request.
    function automatic logic is_legal_amt(input logic [3:0] amt);
        return (amt == 4'd0) || (amt == COIN5) || (amt == COIN10) || (amt == 4'd15);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, ejector, refill and status signals of the change dispenser.
// slave = the dispenser itself, master = the controller/ejector side.
interface change_dispenser_if #(
    parameter int CNT_W = 6
);
    logic             req_valid;
    logic [3:0]       req_amount;
    logic             req_ready;
    logic             eject5;
    logic             eject10;
    logic             eject_ack;
    logic             refill_valid;
    logic             refill_sel;
    logic [CNT_W-1:0] refill_cnt;
    logic             done;
    logic             short;
    logic             bad_amt;
    logic             fault;
    logic [3:0]       residual;
    logic [CNT_W-1:0] stock5;
    logic [CNT_W-1:0] stock10;

    modport slave (
        input  req_valid, req_amount, eject_ack, refill_valid, refill_sel, refill_cnt,
        output req_ready, eject5, eject10, done, short, bad_amt, fault, residual,
               stock5, stock10
    );

    modport master (
        output req_valid, req_amount, eject_ack, refill_valid, refill_sel, refill_cnt,
        input  req_ready, eject5, eject10, done, short, bad_amt, fault, residual,
               stock5, stock10
    );
endinterface

// File: rtl/change_dispenser_ack_watchdog.sv
// Ack watchdog: preloaded down-counter that flags expiry once TIMEOUT
// enabled cycles have elapsed since the last load.
module ack_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Preload on entry to the wait, then count down once per waiting cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Expiry is reported during the last permitted waiting cycle.
    assign o_expired = i_en && (r_cnt == '0);
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change request with 5- and 10-coins through a
// two-chute ejector, one coin per ack, while tracking the coin inventory.
// Optional build macro PARTIAL_DISPENSE_EN: infeasible requests pay the
// greedy maximum and report the unpaid remainder instead of paying nothing.
module change_dispenser
    import change_pkg::*;
#(
    parameter int CNT_W        = 6,
    parameter int STOCK5_INIT  = 8,
    parameter int STOCK10_INIT = 8,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);
    localparam logic [CNT_W-1:0] STOCK_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_remaining;
    logic [3:0]       r_unpaid;
    logic [3:0]       r_residual;
    logic             r_coin10;
    logic             r_done;
    logic             r_short;
    logic             r_bad_amt;
    logic             r_fault;
    logic [CNT_W-1:0] w_stock [2];

    logic             w_legal;
    logic             w_use10;
    logic             w_feasible;
    logic [3:0]       w_rest;
    logic [3:0]       w_need5;
    logic [3:0]       w_rem_after;
    logic             w_ack_take;
    logic             w_req_ready;
    logic             w_eject5;
    logic             w_eject10;
    logic             w_wd_load;
    logic             w_wd_en;
    logic             w_wd_expired;

    // Greedy plan: one 10 when the amount allows and stock has one, rest in 5s.
    assign w_legal     = is_legal_amt(r_remaining);
    assign w_use10     = (r_remaining >= COIN10) && (w_stock[1] != '0);
    assign w_rest      = r_remaining - (w_use10 ? COIN10 : 4'd0);
    assign w_need5     = w_rest / COIN5;
    assign w_feasible  = CNT_W'(w_need5) <= w_stock[0];
    assign w_rem_after = r_remaining - (r_coin10 ? COIN10 : COIN5);
    assign w_ack_take  = (r_state == WAIT_ACK) && bus.eject_ack;

`ifdef PARTIAL_DISPENSE_EN
    logic [3:0] w_pay5;
    logic [3:0] w_payable;
    // When short of 5s, pay every 5-coin still in stock.
    assign w_pay5    = w_feasible ? w_need5 : 4'(w_stock[0]);
    assign w_payable = (w_use10 ? COIN10 : 4'd0) + w_pay5 * COIN5;
`endif

    // One saturating-refill / decrement-on-ack counter per coin type (0 = 5, 1 = 10).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stock
            localparam int INIT = (gi == 0) ? STOCK5_INIT : STOCK10_INIT;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W:0]   w_sum;

            assign w_sum = {1'b0, r_cnt} + {1'b0, bus.refill_cnt};

            // Refill only while idle; a confirmed drop consumes one coin of its chute.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= CNT_W'(INIT);
                end else if ((r_state == IDLE) && bus.refill_valid && (bus.refill_sel == 1'(gi))) begin
                    r_cnt <= w_sum[CNT_W] ? STOCK_MAX : w_sum[CNT_W-1:0];
                end else if (w_ack_take && (r_coin10 == 1'(gi))) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_stock[gi] = r_cnt;
        end
    endgenerate

    ack_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_wd_load),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the Moore outputs (ready, eject strobes, watchdog control).
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_eject5     = 1'b0;
        w_eject10    = 1'b0;
        w_wd_load    = 1'b0;
        w_wd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                w_next_state = IDLE;
                if (w_legal && (r_remaining != '0)) begin
`ifdef PARTIAL_DISPENSE_EN
                    if (w_payable != '0) begin
                        w_next_state = EJECT;
                    end
`else
                    if (w_feasible) begin
                        w_next_state = EJECT;
                    end
`endif
                end
            end
            EJECT: begin
                w_eject10    = w_use10;
                w_eject5     = !w_use10;
                w_wd_load    = 1'b1;
                w_next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                w_wd_en = 1'b1;
                if (bus.eject_ack) begin
                    w_next_state = (w_rem_after == '0) ? IDLE : EJECT;
                end else if (w_wd_expired) begin
                    w_next_state = FAULT;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request bookkeeping, result pulses, residual capture and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_unpaid    <= '0;
            r_residual  <= '0;
            r_coin10    <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_bad_amt   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_short   <= 1'b0;
            r_bad_amt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_remaining <= bus.req_amount;
                        r_unpaid    <= '0;
                    end
                end
                CHECK: begin
                    if (!w_legal) begin
                        r_bad_amt   <= 1'b1;
                        r_remaining <= '0;
                    end else if (r_remaining == '0) begin
                        r_done <= 1'b1;
                    end else if (!w_feasible) begin
`ifdef PARTIAL_DISPENSE_EN
                        r_remaining <= w_payable;
                        r_unpaid    <= r_remaining - w_payable;
                        if (w_payable == '0) begin
                            r_short    <= 1'b1;
                            r_residual <= r_remaining;
                        end
`else
                        r_short     <= 1'b1;
                        r_residual  <= r_remaining;
                        r_remaining <= '0;
`endif
                    end
                end
                EJECT: begin
                    r_coin10 <= w_use10;
                end
                WAIT_ACK: begin
                    if (bus.eject_ack) begin
                        r_remaining <= w_rem_after;
                        if (w_rem_after == '0) begin
                            if (r_unpaid != '0) begin
                                r_short    <= 1'b1;
                                r_residual <= r_unpaid;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end else if (w_wd_expired) begin
                        r_fault    <= 1'b1;
                        r_residual <= r_remaining;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.eject5    = w_eject5;
    assign bus.eject10   = w_eject10;
    assign bus.done      = r_done;
    assign bus.short     = r_short;
    assign bus.bad_amt   = r_bad_amt;
    assign bus.fault     = r_fault;
    assign bus.residual  = r_residual;
    assign bus.stock5    = w_stock[0];
    assign bus.stock10   = w_stock[1];
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: each request pushes its predicted
// result; a monitor pops and compares when done/short/bad_amt/fault appears.
`timescale 1ns/1ps
module tb_change_dispenser;
    localparam int CNT_W       = 6;
    localparam int ACK_TIMEOUT = 15;
    localparam int K_DONE      = 0;
    localparam int K_SHORT     = 1;
    localparam int K_BAD       = 2;
    localparam int K_FAULT     = 3;

    typedef struct {
        int kind;
        int n5;
        int n10;
        int residual;
        int lat;
        int s5;
        int s10;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .CNT_W        (CNT_W),
        .STOCK5_INIT  (8),
        .STOCK10_INIT (8),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks    = 0;
    int   n_fail      = 0;
    exp_t exp_q[$];
    int   m5          = 8;
    int   m10         = 8;
    int   ack_delay   = 0;
    bit   ack_en      = 1'b1;
    logic ack_drv     = 1'b0;
    logic ack_force   = 1'b0;
    int   total_ejects = 0;

    assign bus.eject_ack = ack_drv | ack_force;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: coin-by-coin greedy payout against the model inventory.
    task automatic predict(input int amt, input bit acked, output exp_t e);
        int rem;
        int s5;
        int s10;
        e.kind = K_DONE; e.n5 = 0; e.n10 = 0; e.residual = 0; e.lat = 2;
        e.s5 = m5; e.s10 = m10;
        if (!(amt inside {0, 5, 10, 15})) begin
            e.kind = K_BAD;
            return;
        end
        rem = amt; s5 = m5; s10 = m10;
        while (rem >= 10 && s10 > 0) begin rem -= 10; s10--; e.n10++; end
        while (rem >= 5 && s5 > 0) begin rem -= 5; s5--; e.n5++; end
        if (rem != 0) begin
`ifndef PARTIAL_DISPENSE_EN
            e.n5 = 0; e.n10 = 0; s5 = m5; s10 = m10; rem = amt;
`endif
            e.kind     = K_SHORT;
            e.residual = rem;
        end
        if (!acked && (e.n5 + e.n10) > 0) begin
            e.kind     = K_FAULT;
            e.residual = e.n10 * 10 + e.n5 * 5;
            e.n10      = (e.n10 > 0) ? 1 : 0;
            e.n5       = 1 - e.n10;
            e.lat      = 3 + ACK_TIMEOUT;
            return;
        end
        e.lat = 2 + (e.n5 + e.n10) * (2 + ack_delay);
        e.s5 = s5; e.s10 = s10;
        m5 = s5; m10 = s10;
    endtask

    task automatic send_req(input int amt, input bit push, input bit acked,
                            input bit refill, input bit rsel, input int rcnt);
        exp_t e;
        int   guard;
        guard = 0;
        @(posedge clk); #1;
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check_eq("req_ready_wait", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = 4'(amt);
        if (refill) begin
            bus.refill_valid = 1'b1;
            bus.refill_sel   = rsel;
            bus.refill_cnt   = CNT_W'(rcnt);
            if (rsel) m10 = (m10 + rcnt > 63) ? 63 : m10 + rcnt;
            else      m5  = (m5 + rcnt > 63) ? 63 : m5 + rcnt;
        end
        if (push) begin
            predict(amt, acked, e);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.refill_valid = 1'b0;
    endtask

    task automatic req(input int amt);
        send_req(amt, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic do_refill(input bit sel, input int cnt);
        @(posedge clk); #1;
        bus.refill_valid = 1'b1;
        bus.refill_sel   = sel;
        bus.refill_cnt   = CNT_W'(cnt);
        if (sel) m10 = (m10 + cnt > 63) ? 63 : m10 + cnt;
        else     m5  = (m5 + cnt > 63) ? 63 : m5 + cnt;
        @(posedge clk); #1;
        bus.refill_valid = 1'b0;
        @(negedge clk);
        $display("[%0t] refill sel=%0d cnt=%0d stock=%0d/%0d", $time, sel, cnt, bus.stock5, bus.stock10);
        check_eq("refill_stock5", bus.stock5, m5);
        check_eq("refill_stock10", bus.stock10, m10);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.req_ready !== 1'b1) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) check_eq("idle_timeout", int'(exp_q.size() == 0 && bus.req_ready === 1'b1), 1);
    endtask

    // Ejector model: acknowledges each dropped coin after ack_delay idle cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ack_en && (bus.eject5 || bus.eject10)) begin
                repeat (ack_delay) @(posedge clk);
                @(posedge clk); #1 ack_drv = 1'b1;
                @(posedge clk); #1 ack_drv = 1'b0;
            end
        end
    end

    // Monitor: track latency and ejects per request, compare against the scoreboard.
    initial begin
        exp_t e;
        int   kind_obs;
        int   cyc;
        int   cnt5;
        int   cnt10;
        bit   active;
        logic fault_d;
        cyc = 0; cnt5 = 0; cnt10 = 0; active = 1'b0; fault_d = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active  = 1'b0;
                fault_d = 1'b0;
                continue;
            end
            if (active) cyc++;
            if (bus.eject5)  begin cnt5++;  total_ejects++; end
            if (bus.eject10) begin cnt10++; total_ejects++; end
            if (bus.done || bus.short || bus.bad_amt || (bus.fault && !fault_d)) begin
                kind_obs = bus.done ? K_DONE : bus.short ? K_SHORT : bus.bad_amt ? K_BAD : K_FAULT;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_result", kind_obs, -1);
                end else begin
                    e = exp_q.pop_front();
                    $display("[%0t] result kind=%0d lat=%0d ej5=%0d ej10=%0d residual=%0d stock=%0d/%0d",
                             $time, kind_obs, cyc, cnt5, cnt10, bus.residual, bus.stock5, bus.stock10);
                    check_eq("kind", kind_obs, e.kind);
                    check_eq("latency", cyc, e.lat);
                    check_eq("eject5_count", cnt5, e.n5);
                    check_eq("eject10_count", cnt10, e.n10);
                    if (e.kind == K_SHORT || e.kind == K_FAULT)
                        check_eq("residual", bus.residual, e.residual);
                    check_eq("stock5", bus.stock5, e.s5);
                    check_eq("stock10", bus.stock10, e.s10);
                end
                active = 1'b0;
            end
            fault_d = bus.fault;
            if (bus.req_valid && bus.req_ready) begin
                active = 1'b1; cyc = 0; cnt5 = 0; cnt10 = 0;
            end
        end
    end

    initial begin
        int te;
        exp_t e;
        int c;
        bus.req_valid = 1'b0; bus.req_amount = '0;
        bus.refill_valid = 1'b0; bus.refill_sel = 1'b0; bus.refill_cnt = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_stock5", bus.stock5, 8);
        check_eq("rst_stock10", bus.stock10, 8);
        check_eq("rst_fault", bus.fault, 0);
        check_eq("rst_residual", bus.residual, 0);
        check_eq("rst_pulses", {bus.done, bus.short, bus.bad_amt, bus.eject5, bus.eject10}, 0);

        // Basic payouts, illegal and zero amounts, slow ejector.
        req(15); wait_idle(100);
        req(7);  wait_idle(100);
        req(0);  wait_idle(100);
        ack_delay = 3;
        req(5);  wait_idle(100);
        ack_delay = 0;
        req(10); wait_idle(100);

        // Drain to 0/0, then leave a single 5-coin.
        for (int i = 0; i < 6; i++) begin
            req(15); wait_idle(100);
        end
        do_refill(1'b0, 1);
        req(10); wait_idle(100);
        req(15); wait_idle(100);

        // Refill in the same cycle as the request is visible to CHECK.
        send_req(10, 1'b1, 1'b1, 1'b1, 1'b1, 2); wait_idle(100);

        // Saturating refill.
        do_refill(1'b1, 63);

        // Refill during WAIT_ACK is ignored.
        ack_delay = 5;
        req(10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.refill_valid = 1'b1; bus.refill_sel = 1'b1; bus.refill_cnt = CNT_W'(1);
        @(posedge clk); #1;
        bus.refill_valid = 1'b0;
        wait_idle(100);

        // Reset in the middle of a dispense.
        ack_delay = 8;
        send_req(15, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        $display("[%0t] reset mid-dispense ready=%0d stock=%0d/%0d", $time, bus.req_ready, bus.stock5, bus.stock10);
        check_eq("midrst_ready", bus.req_ready, 1);
        check_eq("midrst_stock5", bus.stock5, 8);
        check_eq("midrst_stock10", bus.stock10, 8);
        m5 = 8; m10 = 8;
        repeat (20) @(posedge clk);
        ack_delay = 0;

        // Ack timeout leads to a sticky fault.
        ack_en = 1'b0;
        send_req(10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin @(posedge clk); #1; c++; end
        if (c >= 100) check_eq("fault_timeout", exp_q.size(), 0);
        @(negedge clk);
        check_eq("fault_flag", bus.fault, 1);
        check_eq("fault_ready", bus.req_ready, 0);
        check_eq("fault_residual", bus.residual, 10);
        te = total_ejects;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_amount = 4'd5; ack_force = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.req_valid = 1'b0; ack_force = 1'b0;
        @(negedge clk);
        $display("[%0t] fault hold fault=%0d ready=%0d stock=%0d/%0d", $time, bus.fault, bus.req_ready, bus.stock5, bus.stock10);
        check_eq("fault_hold_flag", bus.fault, 1);
        check_eq("fault_hold_ready", bus.req_ready, 0);
        check_eq("fault_no_ejects", total_ejects, te);
        check_eq("fault_stock5", bus.stock5, 8);
        check_eq("fault_stock10", bus.stock10, 8);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("fault_cleared", bus.fault, 0);
        check_eq("fault_cleared_ready", bus.req_ready, 1);
        ack_en = 1'b1;

        // Dispenser works again after reset.
        req(15); wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
